if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT control, PC sequencing and a 2-entry {pc, inst} queue toward decode.
// Define IF_FETCH_PERF_EN to build the fetch/stall performance counters; otherwise both ports read 0.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             IM_read,
  output logic [IM_AW-1:0] IM_addr,
  input  logic [31:0]      IM_out,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [31:0]      if_inst,
  output logic [31:0]      if_pc,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, wr_ptr_reg;
  logic [31:0] fifo_pc   [0:1];
  logic [31:0] fifo_inst [0:1];
  logic        push, pop;

  // Target bits below word alignment are dropped on purpose.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign if_valid = (count_reg != 2'd0);
  assign pop      = if_valid & id_ready;
  assign push     = IM_read;
  assign IM_addr  = pc_reg[IM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= BOOT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        BOOT:    state_next = RUN;
        RUN:     state_next = halt_req ? HALT : RUN;
        HALT:    state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  // A pop in the same cycle frees the slot that the new read will fill.
  always_comb begin
    IM_read = 1'b0;
    if (state_reg == RUN && !redirect_valid && (count_reg != 2'd2 || pop))
      IM_read = 1'b1;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (redirect_valid) begin
      pc_reg     <= {redirect_pc[31:2], 2'b00};
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) begin
        pc_reg     <= pc_reg + 32'd4;
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Queue storage needs no reset: count_reg alone decides what is valid.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == 1'(gi)) begin
          fifo_pc[gi]   <= pc_reg;
          fifo_inst[gi] <= IM_out;
        end
      end
    end
  endgenerate

  assign if_inst = if_valid ? fifo_inst[rd_ptr_reg] : 32'd0;
  assign if_pc   = if_valid ? fifo_pc[rd_ptr_reg]   : 32'd0;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (push) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (state_reg == RUN && !IM_read && !redirect_valid)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; memory returns 32'hC0DE_0000 | word address.
// Counter expectations follow whether IF_FETCH_PERF_EN is defined.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        IM_read;
  logic [9:0]  IM_addr;
  logic [31:0] IM_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] s0, f0, exp_s, exp_f;

  if_fetch #(.RESET_PC(32'h0000_0000), .IM_AW(10)) dut (
    .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .IM_out(IM_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  assign IM_out = mem_word(IM_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0; id_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (IM_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%0h exp=0", IM_read); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", if_valid); end
    checks++; if (if_inst !== 32'd0) begin failures++; $display("FAIL rst_inst got=%0h exp=0", if_inst); end
    checks++; if (if_pc !== 32'd0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", if_pc); end
    checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0h/%0h exp=0/0", fetch_cnt, stall_cnt); end
    tick(); rst = 1'b0; #1;
    checks++; if (IM_read !== 1'b0) begin failures++; $display("FAIL boot_read got=%0h exp=0", IM_read); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    tick(); #1;
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'd0) begin failures++; $display("FAIL seq_first got=%0h@%0h exp=1@0", IM_read, IM_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL seq_empty got=%0h exp=0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc%0d got=%0h exp=%0h", i, if_pc, 4 * i); end
      checks++; if (if_inst !== mem_word(10'(i))) begin failures++; $display("FAIL seq_inst%0d got=%0h exp=%0h", i, if_inst, mem_word(10'(i))); end
      checks++; if (IM_addr !== 10'(i + 1)) begin failures++; $display("FAIL seq_addr%0d got=%0h exp=%0h", i, IM_addr, i + 1); end
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    logic [7:0] reads;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1; #1;
    checks++; if (IM_read !== 1'b0) begin failures++; $display("FAIL stall_redir_read got=%0h exp=0", IM_read); end
    tick(); redirect_valid = 1'b0; id_ready = 1'b0; #1;
    s0 = stall_cnt; f0 = fetch_cnt;
    reads = {7'd0, IM_read};
    for (int i = 1; i < 5; i++) begin
      tick(); #1;
      reads = {reads[6:0], IM_read};
    end
    checks++; if (reads[4:0] !== 5'b11000) begin failures++; $display("FAIL stall_reads got=%b exp=11000", reads[4:0]); end
    tick(); id_ready = 1'b1; #1;
`ifdef IF_FETCH_PERF_EN
    exp_s = s0 + 32'd3; exp_f = f0 + 32'd2;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    checks++; if (stall_cnt !== exp_s) begin failures++; $display("FAIL stall_cnt got=%0h exp=%0h", stall_cnt, exp_s); end
    checks++; if (fetch_cnt !== exp_f) begin failures++; $display("FAIL fetch_cnt got=%0h exp=%0h", fetch_cnt, exp_f); end
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'h82) begin failures++; $display("FAIL stall_resume got=%0h@%0h exp=1@82", IM_read, IM_addr); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      checks++; if (if_pc !== 32'h200 + 32'(4 * i) || if_inst !== mem_word(10'(32'h80 + i))) begin
        failures++; $display("FAIL stall_order%0d got=%0h/%0h exp=%0h/%0h", i, if_pc, if_inst, 32'h200 + 32'(4 * i), mem_word(10'(32'h80 + i)));
      end
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect_full();
    tick(); id_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || IM_read !== 1'b0) begin failures++; $display("FAIL full_state got=%0h/%0h exp=1/0", if_valid, IM_read); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; id_ready = 1'b1; #1;
    checks++; if (IM_read !== 1'b0) begin failures++; $display("FAIL full_redir_read got=%0h exp=0", IM_read); end
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL full_flush got=%0h exp=0", if_valid); end
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'd64) begin failures++; $display("FAIL full_addr got=%0h@%0d exp=1@64", IM_read, IM_addr); end
    tick(); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mem_word(10'd64)) begin
      failures++; $display("FAIL full_head got=%0h/%0h exp=100/%0h", if_pc, if_inst, mem_word(10'd64));
    end
    $display("test_redirect_full done");
  endtask

  task automatic test_halt();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300; id_ready = 1'b0; #1;
    tick(); redirect_valid = 1'b0; #1;
    tick(); #1;
    tick(); halt_req = 1'b1; #1;
    checks++; if (IM_read !== 1'b0 || if_pc !== 32'h300) begin failures++; $display("FAIL halt_full got=%0h/%0h exp=0/300", IM_read, if_pc); end
    tick(); halt_req = 1'b0; id_ready = 1'b1; #1;
    s0 = stall_cnt;
    checks++; if (IM_read !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h300) begin failures++; $display("FAIL halt_drain0 got=%0h/%0h/%0h exp=0/1/300", IM_read, if_valid, if_pc); end
    tick(); #1;
    checks++; if (IM_read !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h304) begin failures++; $display("FAIL halt_drain1 got=%0h/%0h/%0h exp=0/1/304", IM_read, if_valid, if_pc); end
    tick(); #1;
    checks++; if (IM_read !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL halt_empty got=%0h/%0h exp=0/0", IM_read, if_valid); end
    tick(); #1;
    checks++; if (IM_read !== 1'b0 || stall_cnt !== s0) begin failures++; $display("FAIL halt_idle got=%0h/%0h exp=0/%0h", IM_read, stall_cnt, s0); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    checks++; if (IM_read !== 1'b0) begin failures++; $display("FAIL halt_redir_read got=%0h exp=0", IM_read); end
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'd16) begin failures++; $display("FAIL halt_resume got=%0h@%0d exp=1@16", IM_read, IM_addr); end
    tick(); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin failures++; $display("FAIL halt_head got=%0h/%0h exp=1/40", if_valid, if_pc); end
    $display("test_halt done");
  endtask

  task automatic test_wrap();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; id_ready = 1'b1; #1;
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'h3FF) begin failures++; $display("FAIL wrap_last got=%0h@%0h exp=1@3ff", IM_read, IM_addr); end
    tick(); #1;
    checks++; if (IM_addr !== 10'd0 || if_pc !== 32'hFFFF_FFFC || if_inst !== mem_word(10'h3FF)) begin
      failures++; $display("FAIL wrap_edge got=%0h/%0h/%0h exp=0/fffffffc/%0h", IM_addr, if_pc, if_inst, mem_word(10'h3FF));
    end
    tick(); #1;
    checks++; if (if_pc !== 32'd0 || if_inst !== mem_word(10'd0)) begin failures++; $display("FAIL wrap_zero got=%0h/%0h exp=0/%0h", if_pc, if_inst, mem_word(10'd0)); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h500; id_ready = 1'b0; #1;
    tick(); redirect_valid = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h500) begin failures++; $display("FAIL mid_full got=%0h/%0h exp=1/500", if_valid, if_pc); end
    rst = 1'b1; #1;
    checks++; if (if_valid !== 1'b0 || IM_read !== 1'b0 || if_pc !== 32'd0) begin failures++; $display("FAIL mid_async got=%0h/%0h/%0h exp=0/0/0", if_valid, IM_read, if_pc); end
    tick(); rst = 1'b0; id_ready = 1'b1; #1;
    checks++; if (IM_read !== 1'b0 || fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL mid_boot got=%0h/%0h/%0h exp=0/0/0", IM_read, fetch_cnt, stall_cnt);
    end
    tick(); #1;
    checks++; if (IM_read !== 1'b1 || IM_addr !== 10'd0 || if_valid !== 1'b0) begin failures++; $display("FAIL mid_restart got=%0h@%0h/%0h exp=1@0/0", IM_read, IM_addr, if_valid); end
    tick(); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin failures++; $display("FAIL mid_head got=%0h/%0h exp=1/0", if_valid, if_pc); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_full();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
